// File: rtl/pe_fetch_arb.sv
// Round-robin fetch arbiter: N_PE fetch ports share one instruction bus with a fixed
// read latency. Any PE RESET line aborts the bus and raises a fixed-length cluster reset.
//
// state | meaning
// IDLE  | no transaction; pick next requester unless cluster reset is held
// WAIT  | bus_ad_o driven, counting down BUS_LAT cycles before sampling bus data
// RESP  | pe_valid_o pulses to the owner; round-robin pointer advances
module pe_fetch_arb #(
  parameter int N_PE      = 4,
  parameter int AD_LEN    = 32,
  parameter int BUS_WIDTH = 32,
  parameter int BUS_LAT   = 2,
  parameter int RST_HOLD  = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [N_PE-1:0]          pe_req_i,
  input  logic [N_PE*AD_LEN-1:0]   pe_ad_i,
  input  logic [N_PE-1:0]          pe_reset_req_i,
  input  logic [BUS_WIDTH-1:0]     bus_data_i,
  output logic [AD_LEN-1:0]        bus_ad_o,
  output logic [N_PE-1:0]          pe_gnt_o,
  output logic [N_PE-1:0]          pe_valid_o,
  output logic [BUS_WIDTH-1:0]     pe_data_o,
  output logic                     pe_reset_o,
  output logic                     busy_o
);

  localparam int IDX_W  = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam int WAIT_W = (BUS_LAT > 1) ? $clog2(BUS_LAT) : 1;
  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               rst_trig;
  logic               rst_nxt;

  // First requester strictly after the last owner, wrapping around.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int k = 1; k <= N_PE; k++) begin
      if (!sel_found && pe_req_i[IDX_W'((int'(last) + k) % N_PE)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'((int'(last) + k) % N_PE);
      end
    end
  end

  assign rst_trig = |pe_reset_req_i;
  assign rst_nxt  = rst_trig | (pe_reset_o & (hold_cnt > HOLD_W'(1)));

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state      <= IDLE;
      last       <= IDX_W'(N_PE - 1);
      idx        <= '0;
      wait_cnt   <= '0;
      hold_cnt   <= '0;
      bus_ad_o   <= '0;
      pe_gnt_o   <= '0;
      pe_valid_o <= '0;
      pe_data_o  <= '0;
      pe_reset_o <= 1'b0;
      busy_o     <= 1'b0;
    end else if (rst_trig) begin
      state      <= IDLE;
      last       <= IDX_W'(N_PE - 1);
      wait_cnt   <= '0;
      hold_cnt   <= HOLD_W'(RST_HOLD);
      bus_ad_o   <= '0;
      pe_gnt_o   <= '0;
      pe_valid_o <= '0;
      pe_reset_o <= 1'b1;
      busy_o     <= 1'b1;
    end else begin
      pe_gnt_o   <= '0;
      pe_valid_o <= '0;
      pe_reset_o <= rst_nxt;
      busy_o     <= rst_nxt;
      if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
      case (state)
        IDLE: begin
          // Requests stay masked through the last hold cycle.
          if (!pe_reset_o && sel_found) begin
            idx               <= sel_idx;
            bus_ad_o          <= pe_ad_i[sel_idx*AD_LEN +: AD_LEN];
            pe_gnt_o[sel_idx] <= 1'b1;
            wait_cnt          <= WAIT_W'(BUS_LAT - 1);
            state             <= WAIT;
            busy_o            <= 1'b1;
          end
        end
        WAIT: begin
          busy_o <= 1'b1;
          if (wait_cnt == '0) begin
            pe_data_o       <= bus_data_i;
            pe_valid_o[idx] <= 1'b1;
            state           <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          last  <= idx;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_fetch_arb.sv
// Bench for pe_fetch_arb: directed scenarios then random traffic, all checked each cycle
// against a timeline model (grant edge + fixed offsets, reset window from last trigger).
module tb_pe_fetch_arb;
  localparam int N_PE = 4, AD_LEN = 32, BUS_WIDTH = 32, BUS_LAT = 2, RST_HOLD = 4;

  logic                   clk_i = 1'b0;
  logic                   reset_i;
  logic [N_PE-1:0]        pe_req_i;
  logic [N_PE*AD_LEN-1:0] pe_ad_i;
  logic [N_PE-1:0]        pe_reset_req_i;
  logic [BUS_WIDTH-1:0]   bus_data_i;
  logic [AD_LEN-1:0]      bus_ad_o;
  logic [N_PE-1:0]        pe_gnt_o;
  logic [N_PE-1:0]        pe_valid_o;
  logic [BUS_WIDTH-1:0]   pe_data_o;
  logic                   pe_reset_o;
  logic                   busy_o;

  always #5 clk_i = ~clk_i;

  pe_fetch_arb #(.N_PE(N_PE), .AD_LEN(AD_LEN), .BUS_WIDTH(BUS_WIDTH),
                 .BUS_LAT(BUS_LAT), .RST_HOLD(RST_HOLD)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .pe_req_i(pe_req_i), .pe_ad_i(pe_ad_i),
    .pe_reset_req_i(pe_reset_req_i), .bus_data_i(bus_data_i), .bus_ad_o(bus_ad_o),
    .pe_gnt_o(pe_gnt_o), .pe_valid_o(pe_valid_o), .pe_data_o(pe_data_o),
    .pe_reset_o(pe_reset_o), .busy_o(busy_o)
  );

  int checks = 0, passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Timeline model: a transaction is fully described by its selection edge and owner.
  int                   e = 0;
  bit                   m_active = 0;
  int                   m_sel = 0, m_owner = 0, m_last = N_PE - 1, m_trig = -1000;
  logic [AD_LEN-1:0]    m_ad = '0;
  logic [BUS_WIDTH-1:0] m_data = '0;
  int                   gidx[$], gcyc[$];
  int                   n_rst = 0, n_valid = 0, n_v0 = 0;

  function automatic int oh_idx(input logic [N_PE-1:0] v);
    int r = -1;
    for (int i = 0; i < N_PE; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic tick();
    logic [N_PE-1:0] exp_gnt, exp_valid;
    logic            exp_rst;
    bit              found;
    int              p;
    e++;
    if (!reset_i) begin
      m_active = 0; m_last = N_PE - 1; m_trig = -1000; m_ad = '0; m_data = '0;
    end else if (pe_reset_req_i != '0) begin
      m_trig = e; m_active = 0; m_last = N_PE - 1; m_ad = '0;
    end else if (m_active) begin
      if (e - m_sel == BUS_LAT) m_data = bus_data_i;
      else if (e - m_sel == BUS_LAT + 1) begin m_last = m_owner; m_active = 0; end
    end else if (e > m_trig + RST_HOLD && pe_req_i != '0) begin
      found = 0;
      for (int s = 1; s <= N_PE; s++) begin
        p = (m_last + s) % N_PE;
        if (!found && pe_req_i[2'(p)]) begin found = 1; m_owner = p; end
      end
      m_active = 1; m_sel = e; m_ad = pe_ad_i[m_owner*AD_LEN +: AD_LEN];
    end
    exp_gnt   = (m_active && e == m_sel) ? N_PE'(1 << m_owner) : '0;
    exp_valid = (m_active && e - m_sel == BUS_LAT) ? N_PE'(1 << m_owner) : '0;
    exp_rst   = (e >= m_trig && e <= m_trig + RST_HOLD - 1);
    @(posedge clk_i);
    #1;
    chk("gnt", pe_gnt_o, exp_gnt);
    chk("valid", pe_valid_o, exp_valid);
    chk("bus_ad", bus_ad_o, m_ad);
    chk("data", pe_data_o, m_data);
    chk("pe_reset", pe_reset_o, exp_rst);
    chk("busy", busy_o, m_active || exp_rst);
    if (pe_gnt_o != '0) begin gidx.push_back(oh_idx(pe_gnt_o)); gcyc.push_back(e); end
    if (pe_reset_o) n_rst++;
    if (pe_valid_o != '0) n_valid++;
    if (pe_valid_o[0]) n_v0++;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 50 && busy_o !== 1'b0; c++) tick();
    chk("idle_reached", busy_o, 1'b0);
  endtask

  initial begin
    reset_i = 1'b0; pe_req_i = '1; pe_reset_req_i = '0; bus_data_i = 32'h1234_5678;
    for (int i = 0; i < N_PE; i++) pe_ad_i[i*AD_LEN +: AD_LEN] = 32'h1000 + 32'(i * 16);

    // Reset with all requests high, then round-robin over 8 transactions.
    repeat (3) tick();
    chk("rst_gnt", pe_gnt_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    reset_i = 1'b1;
    gidx.delete(); gcyc.delete();
    for (int c = 0; c < 100 && gidx.size() < 8; c++) begin
      bus_data_i = $urandom;
      tick();
    end
    chk("rr_count", gidx.size(), 8);
    for (int i = 0; i < gidx.size(); i++) begin
      chk("rr_order", gidx[i], i % N_PE);
      if (i > 0) chk("rr_spacing", gcyc[i] - gcyc[i-1], BUS_LAT + 2);
    end

    // Single fetch from PE2.
    pe_req_i = '0;
    wait_idle();
    pe_req_i = 4'b0100; pe_ad_i[2*AD_LEN +: AD_LEN] = 32'h100; bus_data_i = 32'hDEAD_BEEF;
    n_valid = 0;
    tick();
    chk("single_gnt", pe_gnt_o, 4'b0100);
    chk("single_ad1", bus_ad_o, 32'h100);
    pe_req_i = '0;
    tick();
    chk("single_ad2", bus_ad_o, 32'h100);
    tick();
    chk("single_valid", pe_valid_o, 4'b0100);
    chk("single_data", pe_data_o, 32'hDEAD_BEEF);
    repeat (4) tick();
    chk("single_one_valid", n_valid, 1);

    // Pointer wrap: make PE3 the last owner, then PE1 and PE3 compete.
    wait_idle();
    pe_req_i = 4'b1000;
    for (int c = 0; c < 20 && pe_req_i != '0; c++) begin
      tick();
      pe_req_i = pe_req_i & ~pe_gnt_o;
    end
    wait_idle();
    pe_req_i = 4'b1010;
    gidx.delete(); gcyc.delete();
    for (int c = 0; c < 40 && gidx.size() < 2; c++) begin
      tick();
      pe_req_i = pe_req_i & ~pe_gnt_o;
    end
    chk("wrap_count", gidx.size(), 2);
    if (gidx.size() == 2) begin
      chk("wrap_first", gidx[0], 1);
      chk("wrap_second", gidx[1], 3);
    end

    // Abort PE0's fetch during WAIT.
    wait_idle();
    pe_req_i = 4'b0001;
    tick();
    chk("abort_gnt", pe_gnt_o, 4'b0001);
    pe_req_i = '0; pe_reset_req_i = 4'b0010;
    n_rst = 0; n_v0 = 0;
    tick();
    pe_reset_req_i = '0;
    chk("abort_bus_ad", bus_ad_o, '0);
    repeat (8) tick();
    chk("abort_rst_len", n_rst, RST_HOLD);
    chk("abort_no_valid", n_v0, 0);
    pe_req_i = '1;
    gidx.delete(); gcyc.delete();
    for (int c = 0; c < 20 && gidx.size() < 1; c++) tick();
    chk("abort_regrant", gidx.size(), 1);
    if (gidx.size() > 0) chk("abort_first_pe0", gidx[0], 0);

    // Re-trigger two cycles into the hold, with all requests held.
    gidx.delete(); gcyc.delete();
    n_rst = 0;
    pe_reset_req_i = 4'b0100; tick();
    pe_reset_req_i = '0;      tick();
    pe_reset_req_i = 4'b1000; tick();
    pe_reset_req_i = '0;
    repeat (4) tick();
    chk("retrig_rst_len", n_rst, RST_HOLD + 2);
    chk("retrig_no_gnt", gidx.size(), 0);

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      reset_i        = ($urandom_range(0, 199) != 0);
      pe_req_i       = N_PE'($urandom);
      pe_reset_req_i = ($urandom_range(0, 29) == 0) ? N_PE'($urandom_range(1, 15)) : '0;
      bus_data_i     = $urandom;
      for (int i = 0; i < N_PE; i++) pe_ad_i[i*AD_LEN +: AD_LEN] = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pe_fetch_arb.md
# pe_fetch_arb

Shared-bus fetch arbiter for a multi-PE cluster. It connects N_PE processing-element fetch ports to one instruction bus. Grants go round-robin, one transaction at a time; each transaction waits a programmable bus latency and returns data to the granted PE. The block also aggregates the per-PE RESET line outputs into one cluster-wide reset pulse of fixed length, which aborts any in-flight fetch.

## Interface
- N_PE, 4: number of PE fetch ports (≥2)
- AD_LEN, 32: bus address width
- BUS_WIDTH, 32: bus data width
- BUS_LAT, 2: cycles bus_ad_o is held before bus_data_i is sampled (≥1)
- RST_HOLD, 4: cycles pe_reset_o stays high per trigger (≥1)

- clk_i  in  1  clock, all logic on rising edge
- reset_i  in  1  synchronous, active-low reset
- pe_req_i  in  N_PE  per-PE fetch request
- pe_ad_i  in  N_PE*AD_LEN  per-PE fetch address; PE i at [i*AD_LEN +: AD_LEN]
- pe_reset_req_i  in  N_PE  per-PE RESET line (active-high)
- bus_data_i  in  BUS_WIDTH  bus read data
- bus_ad_o  out  AD_LEN  bus address (registered)
- pe_gnt_o  out  N_PE  one-hot grant pulse
- pe_valid_o  out  N_PE  one-hot data-valid pulse
- pe_data_o  out  BUS_WIDTH  returned data, shared by all PEs
- pe_reset_o  out  1  cluster reset to all PEs (active-high)
- busy_o  out  1  high whenever state ≠ IDLE or pe_reset_o is high

## Operation
- All outputs are registered. Reset (reset_i=0 at an edge) sets:
  - bus_ad_o=0, pe_gnt_o=0, pe_valid_o=0, pe_data_o=0, pe_reset_o=0, busy_o=0
  - state=IDLE, wait counter=0, hold counter=0
  - last-grant pointer=N_PE-1, so PE0 wins first.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if any pe_req_i bit is set, select the first requesting index scanning from (last+1) mod N_PE upward with wrap. Latch that index and its pe_ad_i slice. Next cycle: pe_gnt_o[idx]=1 for exactly one cycle, bus_ad_o=latched address, counter=BUS_LAT-1, go to WAIT. With no requests, stay in IDLE; bus_ad_o holds its last value.
  - WAIT: bus_ad_o held. At each edge, if counter==0, capture bus_data_i into pe_data_o and go to RESP; otherwise decrement the counter.
  - RESP: pe_valid_o[idx]=1 for one cycle, pe_data_o stable, last=idx. Then go to IDLE.
- Requesters hold pe_req_i and pe_ad_i stable until they see their gnt. The address is latched at the selection edge, so it may change from the grant cycle on.
  - A request dropped before its grant is withdrawn with no effect.
  - A request held high during the PE's own RESP cycle counts as a new request.
- pe_data_o keeps the last captured value outside RESP.
- Reset aggregation:
  - When any pe_reset_req_i bit is high at an edge, whatever the state, pe_reset_o=1 and the hold counter loads RST_HOLD.
  - The in-flight transaction aborts: no pe_valid_o is issued and any pending gnt is cleared. State goes to IDLE, bus_ad_o=0, last=N_PE-1.
  - While pe_reset_o=1, requests are ignored.
  - A re-trigger during the hold reloads the counter to RST_HOLD.
  - pe_reset_o deasserts after RST_HOLD cycles with no trigger.
- Same-edge priority: reset_i > pe_reset_req_i > FSM progress.

## Timing
- Request sampled at edge E0 in IDLE:
  - grant and bus address are visible in cycle E0+1
  - bus_data_i is sampled at edge E0+BUS_LAT
  - pe_valid_o is high in cycle E0+BUS_LAT+1
- Back to IDLE the cycle after RESP. The next grant is visible at E0+BUS_LAT+3, so sustained throughput is one fetch per BUS_LAT+2 cycles.
- A pe_reset_req_i seen at edge E makes pe_reset_o high during cycles E+1 through E+RST_HOLD.
- Grant order with all requests held high: 0,1,…,N_PE-1,0,… This guarantees no starvation; worst-case wait is (N_PE-1)(BUS_LAT+2) cycles.

## Test plan
- Reset: hold reset_i=0 for 3 cycles with all req high → all outputs 0. On release, the first grant goes to PE0.
- Single fetch, BUS_LAT=2: PE2 requests addr 0x100, bus returns 0xDEADBEEF.
  - Required: gnt[2] in cycle 1, bus_ad_o=0x100 in cycles 1–2, valid[2] with data 0xDEADBEEF in cycle 3, and exactly one valid pulse.
- Round-robin: all 4 PEs request continuously for 8 transactions → grants 0,1,2,3,0,1,2,3, with successive grants spaced 4 cycles apart.
- Pointer wrap: last=3 with only PE1 and PE3 requesting → PE1 is granted next, then PE3.
- Abort: pe_reset_req_i[1] pulses during WAIT of PE0's fetch.
  - Required: no valid[0], bus_ad_o=0, pe_reset_o high for exactly 4 cycles.
  - After release, the first grant goes to PE0.
- Re-trigger: a second reset request arrives 2 cycles into the hold → pe_reset_o stays high 6 cycles total, and no grants occur during the hold.
